mul_add_pipe: RTL and testbench
===============================

Name: mul_add_pipe

Overview:
- Parametrised, fully pipelined signed arithmetic unit for the SCGRA processing element.
- Successor to the fixed multiply-add unit. Adds:
  - generic DWIDTH,
  - configurable multiplier pipeline depth,
  - an opcode-selected mode set including an internal accumulator (MAC),
  - valid tagging and a global stall.
- Accepts one operation per cycle; sits between PE operand muxes and the PE result register.

Parameters:
- DWIDTH, 32, operand/result width in bits (>=4).
- MUL_STAGES, 2, multiplier pipeline registers (1..4); total latency L = MUL_STAGES+1.
- OP_W, 3, opcode width.

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- stall  in  1  1 = freeze every pipeline register and the accumulator.
- in_valid  in  1  operation present on inputs this cycle.
- opcode  in  OP_W  operation select (see Behaviour).
- acc_clr  in  1  with a MAC op: accumulate from 0 instead of the current accumulator.
- a  in  DWIDTH  signed operand A.
- b  in  DWIDTH  signed operand B.
- c  in  DWIDTH  signed operand C.
- out_valid  out  1  p carries a result.
- p  out  DWIDTH  result.
- ovf  out  1  result saturated (see Optional Feature).

Behaviour:
- Reset:
  - Asserting Reset asynchronously clears all pipeline registers, the accumulator, out_valid, p and ovf to 0, including mid-operation; in-flight ops are discarded.
  - First op accepted on the first clk edge after Reset deasserts.
- Opcodes:
  - 0 ADD: p=a+b
  - 1 SUB: p=a-b
  - 2 MUL: p=a*b
  - 3 MULADD: p=a*b+c
  - 4 MULSUB: p=a*b-c
  - 5 MAC: acc=(acc_clr?0:acc)+a*b, p=new acc
  - 6 PASS: p=a
  - 7 NOP: out_valid stays 0, no acc change
- Pipeline:
  - Stage 1 registers a,b,c,opcode,acc_clr,valid.
  - Product is 2*DWIDTH wide and passes through MUL_STAGES registers total, counted from stage 1.
  - The final stage performs the add/sub/acc and registers p, out_valid, ovf.
  - c, opcode and valid are delayed alongside the product.
  - ADD/SUB/PASS use the same latency L (no bypass); results leave strictly in issue order.
- Latency and throughput:
  - Op sampled at edge k (stall=0) appears at edge k+L.
  - Default L=3. MUL_STAGES=1 gives L=2.
  - Throughput 1 op/cycle.
- Invalid slots:
  - in_valid=0 inserts a bubble: out_valid=0 at that slot.
  - p holds its previous value; acc is unchanged.
- Widths:
  - Product truncated to low DWIDTH bits (two's-complement wrap) before the final add.
  - Sums wrap modulo 2^DWIDTH.
  - acc is DWIDTH bits.
- MAC:
  - acc is read and written in the final stage only, so back-to-back MACs chain with no hazard.
  - acc_clr is ignored for non-MAC ops.
  - Non-MAC ops never alter acc.
- stall:
  - Synchronous hold: all registers keep their values, including out_valid and p.
  - Inputs presented during stall are ignored (the producer must hold them).
  - Stall asserted on the same edge as an op: the op is not sampled.

Optional Feature:
- Macro MUL_ADD_PIPE_SAT_EN.
- Defined:
  - Product is saturated to the signed DWIDTH range before the final add.
  - The final add/sub/acc is computed at DWIDTH+1 bits and clamped to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
  - ovf=1 for the result slot if either clamp fired; ovf carries the same valid timing as p.
- Undefined:
  - Wrap arithmetic as above; ovf tied 0.

Decomposition:
- Package mul_add_pkg:
  - OP_W.
  - Opcode constants OP_ADD..OP_NOP.
  - Function sat_clamp(value, width) used when the macro is on.
- Sub-module pipe_mul:
  - Signed DWIDTH x DWIDTH multiplier, 2*DWIDTH output, MUL_STAGES register stages, with stall as clock enable and Reset.
  - Lets synthesis retime onto DSP slices.

Test Plan:
- MULADD a=3,b=-4,c=5, valid at edge 0 -> edge 3: p=-7, out_valid=1; edge 4: out_valid=0, p=-7 held.
- Back-to-back, one op per cycle: ADD(7,8), SUB(7,8), MUL(-6,7), PASS(0x1234) -> p=15,-1,-42,0x1234 on consecutive edges 3..6; a bubble between two ops gives exactly one out_valid=0 slot.
- MAC with acc_clr=1 (2,3), then MAC (4,5), then MAC (-1,1) -> p=6, 26, 25. An interleaved MUL(9,9) gives p=81 and the following MAC continues from 26.
- Stall:
  - Issue MULSUB(10,10,1).
  - Assert stall for 4 cycles starting 1 edge later.
  - Result p=99 appears at edge 3+4.
  - Outputs stay frozen during stall, including a previously valid p.
- Reset:
  - Assert Reset asynchronously between edges with 2 ops in flight and acc=26.
  - p, out_valid, ovf and acc go to 0 immediately; no result emerges.
  - The next MAC(1,1) without acc_clr gives p=1.
- With MUL_ADD_PIPE_SAT_EN, DWIDTH=8:
  - MUL(100,2) -> p=127, ovf=1.
  - ADD(-100,-100) -> p=-128, ovf=1.
  - Without the macro, MUL(100,2) -> p=-56, ovf=0.

Source files
------------

// File: rtl/mul_add_pkg.sv
// rtl/mul_add_pkg.sv - opcodes and saturation helpers for mul_add_pipe
// sat_clamp is only referenced when MUL_ADD_PIPE_SAT_EN is defined.
package mul_add_pkg;

   localparam int OP_W     = 3;
   // Wide enough for a sign-extended 2*DWIDTH product up to DWIDTH=64.
   localparam int SAT_MAXW = 130;

   typedef enum logic [OP_W-1:0] {
      OP_ADD    = 3'd0,
      OP_SUB    = 3'd1,
      OP_MUL    = 3'd2,
      OP_MULADD = 3'd3,
      OP_MULSUB = 3'd4,
      OP_MAC    = 3'd5,
      OP_PASS   = 3'd6,
      OP_NOP    = 3'd7
   } op_e;

   function automatic logic signed [SAT_MAXW-1:0] sat_clamp(
      input logic signed [SAT_MAXW-1:0] value,
      input int                         width
   );
      logic signed [SAT_MAXW-1:0] max_v;
      logic signed [SAT_MAXW-1:0] min_v;
      max_v = (SAT_MAXW'(1) << (width - 1)) - SAT_MAXW'(1);
      min_v = ~max_v;
      if (value > max_v) return max_v;
      if (value < min_v) return min_v;
      return value;
   endfunction

   function automatic logic op_uses_mul(input logic [OP_W-1:0] op);
      return (op == OP_MUL) || (op == OP_MULADD) || (op == OP_MULSUB) || (op == OP_MAC);
   endfunction

endpackage

// File: rtl/pipe_mul.sv
// rtl/pipe_mul.sv - signed DWIDTH x DWIDTH multiplier with MUL_STAGES registers
// A plain register chain after the multiply so synthesis can retime it into DSP slices.
module pipe_mul #(
   parameter int DWIDTH     = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       en_i,
   input  logic signed [DWIDTH-1:0]   a_i,
   input  logic signed [DWIDTH-1:0]   b_i,
   output logic signed [2*DWIDTH-1:0] p_o
);

   logic signed [2*DWIDTH-1:0] prod_d;
   logic signed [2*DWIDTH-1:0] prod_q [MUL_STAGES];

   assign prod_d = (2*DWIDTH)'(a_i) * (2*DWIDTH)'(b_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < MUL_STAGES; i++) prod_q[i] <= '0;
      end else if (en_i) begin
         prod_q[0] <= prod_d;
         for (int i = 1; i < MUL_STAGES; i++) prod_q[i] <= prod_q[i-1];
      end
   end

   assign p_o = prod_q[MUL_STAGES-1];

endmodule

// File: rtl/mul_add_pipe.sv
// rtl/mul_add_pipe.sv - pipelined signed add/sub/mul/MAC unit, latency MUL_STAGES+1
// MUL_ADD_PIPE_SAT_EN selects saturating arithmetic with ovf; otherwise results wrap.
module mul_add_pipe #(
   parameter int DWIDTH     = 32,
   parameter int MUL_STAGES = 2,
   parameter int OP_W       = mul_add_pkg::OP_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              in_valid_i,
   input  logic [OP_W-1:0]   opcode_i,
   input  logic              acc_clr_i,
   input  logic [DWIDTH-1:0] a_i,
   input  logic [DWIDTH-1:0] b_i,
   input  logic [DWIDTH-1:0] c_i,
   output logic              out_valid_o,
   output logic [DWIDTH-1:0] p_o,
   output logic              ovf_o
);
   import mul_add_pkg::*;

   typedef struct packed {
      logic              valid;
      logic [OP_W-1:0]   op;
      logic              clr;
      logic [DWIDTH-1:0] a;
      logic [DWIDTH-1:0] b;
      logic [DWIDTH-1:0] c;
   } slot_t;

   slot_t s1_d;
   slot_t s1_q;
   slot_t side_q [MUL_STAGES];
   slot_t fin;

   logic signed [2*DWIDTH-1:0] prod_w;
   logic signed [DWIDTH-1:0]   mul_w;
   logic        [DWIDTH-1:0]   base_w;
   logic        [DWIDTH:0]     sum_w;
   logic        [DWIDTH-1:0]   res_d;
   logic                       ovf_d;

   logic [DWIDTH-1:0] acc_q;
   logic [DWIDTH-1:0] p_q;
   logic              out_valid_q;
   logic              ovf_q;

   function automatic logic [DWIDTH:0] sx(input logic [DWIDTH-1:0] x);
      return {x[DWIDTH-1], x};
   endfunction

   // NOPs are dropped at the input so they travel as bubbles.
   always_comb begin
      s1_d       = '0;
      s1_d.valid = in_valid_i && (opcode_i != OP_W'(OP_NOP));
      s1_d.op    = opcode_i;
      s1_d.clr   = acc_clr_i;
      s1_d.a     = a_i;
      s1_d.b     = b_i;
      s1_d.c     = c_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q <= '0;
         for (int i = 0; i < MUL_STAGES; i++) side_q[i] <= '0;
      end else if (!stall_i) begin
         s1_q      <= s1_d;
         side_q[0] <= s1_q;
         for (int i = 1; i < MUL_STAGES; i++) side_q[i] <= side_q[i-1];
      end
   end

   pipe_mul #(
      .DWIDTH     (DWIDTH),
      .MUL_STAGES (MUL_STAGES)
   ) u_mul (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (!stall_i),
      .a_i   (s1_q.a),
      .b_i   (s1_q.b),
      .p_o   (prod_w)
   );

   assign fin = side_q[MUL_STAGES-1];

   // Computed one bit wider so the saturating build can see the true sum.
   always_comb begin
      base_w = fin.clr ? '0 : acc_q;
      sum_w  = sx(fin.a);
      case (fin.op)
         OP_W'(OP_ADD):    sum_w = sx(fin.a) + sx(fin.b);
         OP_W'(OP_SUB):    sum_w = sx(fin.a) - sx(fin.b);
         OP_W'(OP_MUL):    sum_w = sx(mul_w);
         OP_W'(OP_MULADD): sum_w = sx(mul_w) + sx(fin.c);
         OP_W'(OP_MULSUB): sum_w = sx(mul_w) - sx(fin.c);
         OP_W'(OP_MAC):    sum_w = sx(base_w) + sx(mul_w);
         default:          sum_w = sx(fin.a);
      endcase
   end

`ifdef MUL_ADD_PIPE_SAT_EN
   logic signed [SAT_MAXW-1:0] prod_x;
   logic signed [SAT_MAXW-1:0] prod_c;
   logic signed [SAT_MAXW-1:0] sum_x;
   logic signed [SAT_MAXW-1:0] sum_c;
   logic                       prod_ovf;

   assign prod_x   = {{(SAT_MAXW-2*DWIDTH){prod_w[2*DWIDTH-1]}}, prod_w};
   assign prod_c   = sat_clamp(prod_x, DWIDTH);
   assign prod_ovf = (prod_c != prod_x);
   assign mul_w    = prod_c[DWIDTH-1:0];

   assign sum_x = {{(SAT_MAXW-DWIDTH-1){sum_w[DWIDTH]}}, sum_w};
   assign sum_c = sat_clamp(sum_x, DWIDTH);
   assign res_d = sum_c[DWIDTH-1:0];
   assign ovf_d = (sum_c != sum_x) || (prod_ovf && op_uses_mul(fin.op));
`else
   logic prod_hi_unused;
   logic sum_msb_unused;

   assign mul_w          = prod_w[DWIDTH-1:0];
   assign prod_hi_unused = ^prod_w[2*DWIDTH-1:DWIDTH];
   assign res_d          = sum_w[DWIDTH-1:0];
   assign sum_msb_unused = sum_w[DWIDTH];
   assign ovf_d          = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q       <= '0;
         p_q         <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (!stall_i) begin
         out_valid_q <= fin.valid;
         if (fin.valid) begin
            p_q   <= res_d;
            ovf_q <= ovf_d;
            if (fin.op == OP_W'(OP_MAC)) acc_q <= res_d;
         end else begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign p_o         = p_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_mul_add_pipe.sv
// tb/tb_mul_add_pipe.sv - directed self-checking bench for mul_add_pipe
// The 8-bit instance expectations follow MUL_ADD_PIPE_SAT_EN.
module tb_mul_add_pipe;
   import mul_add_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  opcode = 3'd7;
   logic        acc_clr = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] c = '0;
   logic        out_valid;
   logic [31:0] p;
   logic        ovf;

   logic        in_valid8 = 1'b0;
   logic [2:0]  opcode8 = 3'd7;
   logic        acc_clr8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic [7:0]  c8 = '0;
   logic        out_valid8;
   logic [7:0]  p8;
   logic        ovf8;

   int total = 0;
   int bad   = 0;

`ifdef MUL_ADD_PIPE_SAT_EN
   localparam logic [7:0] EXP_MUL8 = 8'h7F;
   localparam logic [7:0] EXP_ADD8 = 8'h80;
   localparam logic       EXP_OVF8 = 1'b1;
`else
   localparam logic [7:0] EXP_MUL8 = 8'hC8;
   localparam logic [7:0] EXP_ADD8 = 8'h38;
   localparam logic       EXP_OVF8 = 1'b0;
`endif

   always #5 clk = ~clk;

   mul_add_pipe dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .stall_i     (stall),
      .in_valid_i  (in_valid),
      .opcode_i    (opcode),
      .acc_clr_i   (acc_clr),
      .a_i         (a),
      .b_i         (b),
      .c_i         (c),
      .out_valid_o (out_valid),
      .p_o         (p),
      .ovf_o       (ovf)
   );

   mul_add_pipe #(.DWIDTH(8), .MUL_STAGES(1)) dut8 (
      .clk_i       (clk),
      .rst_i       (rst),
      .stall_i     (stall),
      .in_valid_i  (in_valid8),
      .opcode_i    (opcode8),
      .acc_clr_i   (acc_clr8),
      .a_i         (a8),
      .b_i         (b8),
      .c_i         (c8),
      .out_valid_o (out_valid8),
      .p_o         (p8),
      .ovf_o       (ovf8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic v, input logic [2:0] op, input logic clr,
                       input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv);
      in_valid = v;
      opcode   = op;
      acc_clr  = clr;
      a        = av;
      b        = bv;
      c        = cv;
      tick();
   endtask

   task automatic idle();
      step(1'b0, OP_NOP, 1'b0, 32'd0, 32'd0, 32'd0);
   endtask

   initial begin
      tick();
      chk("rst_p", p, 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_p8", 32'(p8), 32'd0);
      chk("rst_valid8", 32'(out_valid8), 32'd0);
      rst = 1'b0;

      // MULADD latency and hold
      step(1'b1, OP_MULADD, 1'b0, 32'd3, -32'sd4, 32'd5);
      idle();
      chk("muladd_e1_valid", 32'(out_valid), 32'd0);
      idle();
      chk("muladd_e2_valid", 32'(out_valid), 32'd0);
      idle();
      chk("muladd_p", p, -32'sd7);
      chk("muladd_valid", 32'(out_valid), 32'd1);
      chk("muladd_ovf", 32'(ovf), 32'd0);
      idle();
      chk("muladd_after_valid", 32'(out_valid), 32'd0);
      chk("muladd_after_p", p, -32'sd7);

      // back-to-back with one bubble
      step(1'b1, OP_ADD, 1'b0, 32'd7, 32'd8, 32'd0);
      step(1'b1, OP_SUB, 1'b0, 32'd7, 32'd8, 32'd0);
      step(1'b1, OP_MUL, 1'b0, -32'sd6, 32'd7, 32'd0);
      step(1'b1, OP_PASS, 1'b0, 32'h1234, 32'd0, 32'd0);
      chk("b2b_add", p, 32'd15);
      chk("b2b_add_valid", 32'(out_valid), 32'd1);
      idle();
      chk("b2b_sub", p, -32'sd1);
      step(1'b1, OP_ADD, 1'b0, 32'd1, 32'd1, 32'd0);
      chk("b2b_mul", p, -32'sd42);
      idle();
      chk("b2b_pass", p, 32'h1234);
      chk("b2b_pass_valid", 32'(out_valid), 32'd1);
      idle();
      chk("bubble_valid", 32'(out_valid), 32'd0);
      chk("bubble_p_hold", p, 32'h1234);
      idle();
      chk("after_bubble", p, 32'd2);
      chk("after_bubble_valid", 32'(out_valid), 32'd1);

      // MAC chain with an interleaved MUL
      step(1'b1, OP_MAC, 1'b1, 32'd2, 32'd3, 32'd0);
      step(1'b1, OP_MAC, 1'b0, 32'd4, 32'd5, 32'd0);
      step(1'b1, OP_MUL, 1'b1, 32'd9, 32'd9, 32'd0);
      step(1'b1, OP_MAC, 1'b0, -32'sd1, 32'd1, 32'd0);
      chk("mac_clr", p, 32'd6);
      idle();
      chk("mac_chain", p, 32'd26);
      idle();
      chk("mac_mul", p, 32'd81);
      idle();
      chk("mac_continue", p, 32'd25);

      // stall freezes a valid result and the in-flight op
      step(1'b1, OP_ADD, 1'b0, 32'd20, 32'd22, 32'd0);
      idle();
      idle();
      step(1'b1, OP_MULSUB, 1'b0, 32'd10, 32'd10, 32'd1);
      chk("pre_stall_p", p, 32'd42);
      stall    = 1'b1;
      in_valid = 1'b1;
      opcode   = OP_ADD;
      a        = 32'd1;
      b        = 32'd2;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_p", p, 32'd42);
         chk("stall_valid", 32'(out_valid), 32'd1);
      end
      stall = 1'b0;
      idle();
      chk("post_stall_e5", 32'(out_valid), 32'd0);
      chk("post_stall_e5_p", p, 32'd42);
      idle();
      chk("post_stall_e6", 32'(out_valid), 32'd0);
      idle();
      chk("mulsub_p", p, 32'd99);
      chk("mulsub_valid", 32'(out_valid), 32'd1);
      idle();
      chk("stall_input_ignored", 32'(out_valid), 32'd0);

      // asynchronous reset with ops in flight and acc=26
      step(1'b1, OP_MAC, 1'b1, 32'd2, 32'd3, 32'd0);
      step(1'b1, OP_MAC, 1'b0, 32'd4, 32'd5, 32'd0);
      idle();
      idle();
      idle();
      chk("acc_26", p, 32'd26);
      step(1'b1, OP_MAC, 1'b0, 32'd7, 32'd7, 32'd0);
      step(1'b1, OP_ADD, 1'b0, 32'd1, 32'd1, 32'd0);
      rst = 1'b1;
      #2;
      chk("async_rst_p", p, 32'd0);
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_ovf", 32'(ovf), 32'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_flushed", 32'(out_valid), 32'd0);
      end
      step(1'b1, OP_MAC, 1'b0, 32'd1, 32'd1, 32'd0);
      idle();
      idle();
      idle();
      chk("mac_after_rst", p, 32'd1);
      chk("mac_after_rst_valid", 32'(out_valid), 32'd1);

      // 8-bit instance, one multiplier stage (latency 2)
      in_valid8 = 1'b1;
      opcode8   = OP_MUL;
      a8        = 8'd100;
      b8        = 8'd2;
      tick();
      opcode8 = OP_ADD;
      a8      = 8'h9C;
      b8      = 8'h9C;
      tick();
      chk("w8_latency", 32'(out_valid8), 32'd0);
      opcode8 = OP_MULADD;
      a8      = 8'd10;
      b8      = 8'd10;
      c8      = 8'd5;
      tick();
      chk("w8_mul_p", 32'(p8), 32'(EXP_MUL8));
      chk("w8_mul_ovf", 32'(ovf8), 32'(EXP_OVF8));
      chk("w8_mul_valid", 32'(out_valid8), 32'd1);
      in_valid8 = 1'b0;
      tick();
      chk("w8_add_p", 32'(p8), 32'(EXP_ADD8));
      chk("w8_add_ovf", 32'(ovf8), 32'(EXP_OVF8));
      tick();
      chk("w8_muladd_p", 32'(p8), 32'd105);
      chk("w8_muladd_ovf", 32'(ovf8), 32'd0);
      tick();
      chk("w8_idle_valid", 32'(out_valid8), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
